fetch_sequencer: RTL and testbench

//  Control FSM for the instruction-fetch stage. Sequences fetch through IDLE/RUN/FLUSH/HALT and picks
//  the next PC by fixed priority: jump > branch > md_jal > sequential.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_sequencer_sat_counter.sv | 31 +++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared state encodings and constants for the instruction-fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module : fetch_sequencer
// Brief  : Fetch-stage control FSM with prioritised next-PC select, IR bubble
//          insertion after redirects, and redirect/stall perf counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             jump,
    input  logic             branch,
    input  logic             md_jal,
    input  logic [31:0]      jump_addr,
    input  logic [31:0]      branch_addr,
    input  logic [31:0]      md_jaladdr,
    input  logic [31:0]      pc_cur,
    output logic [1:0]       curr_state,
    output logic [31:0]      pc_next,
    output logic             pc_we,
    output logic             ir_write,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] c_flush_reload = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_fcnt;
    logic [2:0]  w_fcnt_nxt;
    logic        w_redir;
    logic [31:0] w_tgt;
    logic [31:0] w_pc_seq;
    logic        w_redir_inc;
    logic        w_stall_inc;

    assign w_redir  = jump | branch | md_jal;
    assign w_pc_seq = pc_cur + PC_INC;
    assign w_tgt    = jump   ? jump_addr   :
                      branch ? branch_addr :
                               md_jaladdr + PC_INC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        pc_next     = w_pc_seq;
        pc_we       = 1'b0;
        ir_write    = 1'b0;
        flush       = 1'b0;
        w_redir_inc = 1'b0;
        w_stall_inc = 1'b0;

        case (r_state)
            ST_IDLE: begin
                pc_next = RESET_PC;
                pc_we   = 1'b1;
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end else if (w_redir) begin
                    pc_next     = w_tgt;
                    pc_we       = 1'b1;
                    ir_write    = 1'b1;
                    flush       = 1'b1;
                    w_redir_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_fcnt_nxt  = c_flush_reload;
                        w_state_nxt = ST_FLUSH;
                    end
                end else if (stall) begin
                    w_stall_inc = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    ir_write = 1'b1;
                end
            end

            ST_FLUSH: begin
                // Bubbles keep loading into IR even while stalled, so the
                // remaining flush count only advances on non-stalled cycles.
                flush    = 1'b1;
                ir_write = 1'b1;
                if (w_redir) begin
                    pc_next     = w_tgt;
                    pc_we       = 1'b1;
                    w_fcnt_nxt  = c_flush_reload;
                    w_redir_inc = 1'b1;
                end else if (!stall) begin
                    pc_we      = 1'b1;
                    w_fcnt_nxt = r_fcnt - 3'd1;
                    if (r_fcnt == 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_HALT: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign curr_state = r_state;

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_redir_inc),
        .q   (redirect_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .q   (stall_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module : tb_fetch_sequencer
// Brief  : Directed vector bench for fetch_sequencer (default and 3-cycle
//          flush / 4-bit counter configurations).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    localparam logic [31:0] DC = 32'hDEAD_BEEF;

    typedef struct {
        logic [5:0]  ctl;    // {start, halt_req, stall, jump, branch, md_jal}
        logic [31:0] jaddr;
        logic [31:0] baddr;
        logic [31:0] maddr;
        logic [31:0] pc_cur;
        logic [1:0]  st;
        logic [31:0] pcn;
        logic        we;
        logic        ir;
        logic        fl;
        logic [15:0] rc;
        logic [15:0] sc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt_req, stall, jump, branch, md_jal;
    logic [31:0] jump_addr, branch_addr, md_jaladdr, pc_cur;

    logic [1:0]  a_st, b_st;
    logic [31:0] a_pcn, b_pcn;
    logic        a_we, b_we, a_ir, b_ir, a_fl, b_fl;
    logic [15:0] a_rc, a_sc;
    logic [3:0]  b_rc, b_sc;

    logic        sel_b;
    int          n_vec  = 0;
    int          n_fail = 0;

    vec_t ta [19];
    vec_t tb [16];

    always #5 clk = ~clk;

    fetch_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
        .jump(jump), .branch(branch), .md_jal(md_jal),
        .jump_addr(jump_addr), .branch_addr(branch_addr), .md_jaladdr(md_jaladdr),
        .pc_cur(pc_cur), .curr_state(a_st), .pc_next(a_pcn), .pc_we(a_we),
        .ir_write(a_ir), .flush(a_fl), .redirect_cnt(a_rc), .stall_cnt(a_sc)
    );

    fetch_sequencer #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
        .jump(jump), .branch(branch), .md_jal(md_jal),
        .jump_addr(jump_addr), .branch_addr(branch_addr), .md_jaladdr(md_jaladdr),
        .pc_cur(pc_cur), .curr_state(b_st), .pc_next(b_pcn), .pc_we(b_we),
        .ir_write(b_ir), .flush(b_fl), .redirect_cnt(b_rc), .stall_cnt(b_sc)
    );

    function automatic vec_t mk(input logic [5:0] ctl, input logic [31:0] ja, input logic [31:0] ba,
                                input logic [31:0] ma, input logic [31:0] pc, input logic [1:0] st,
                                input logic [31:0] pcn, input logic we, input logic ir, input logic fl,
                                input logic [15:0] rc, input logic [15:0] sc);
        vec_t v;
        v.ctl = ctl; v.jaddr = ja; v.baddr = ba; v.maddr = ma; v.pc_cur = pc;
        v.st = st; v.pcn = pcn; v.we = we; v.ir = ir; v.fl = fl; v.rc = rc; v.sc = sc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        {start, halt_req, stall, jump, branch, md_jal} = v.ctl;
        jump_addr   = v.jaddr;
        branch_addr = v.baddr;
        md_jaladdr  = v.maddr;
        pc_cur      = v.pc_cur;
    endtask

    // Called at a negedge: drive, settle, compare, then advance to the next negedge.
    task automatic apply(input vec_t v, input string name);
        logic [1:0]  st;
        logic [31:0] pcn;
        logic        we, ir, fl, bad;
        logic [15:0] rc, sc;
        drive(v);
        #1;
        if (sel_b) begin
            st = b_st; pcn = b_pcn; we = b_we; ir = b_ir; fl = b_fl;
            rc = {12'd0, b_rc}; sc = {12'd0, b_sc};
        end else begin
            st = a_st; pcn = a_pcn; we = a_we; ir = a_ir; fl = a_fl; rc = a_rc; sc = a_sc;
        end
        n_vec++;
        bad = (st !== v.st) || (we !== v.we) || (ir !== v.ir) || (fl !== v.fl) ||
              (rc !== v.rc) || (sc !== v.sc) || ((v.pcn != DC) && (pcn !== v.pcn));
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got st=%0d pc=%h we=%b ir=%b fl=%b rc=%0d sc=%0d; want st=%0d pc=%h we=%b ir=%b fl=%b rc=%0d sc=%0d",
                     name, st, pcn, we, ir, fl, rc, sc, v.st, v.pcn, v.we, v.ir, v.fl, v.rc, v.sc);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(mk(6'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //             ctl        jaddr        baddr      maddr         pc_cur        st  pc_next       we ir fl rc sc
        ta[0]  = mk(6'b000000, 0,           0,         0,            0,            0, 32'h0,         1, 0, 0, 0, 0);
        ta[1]  = mk(6'b001100, 32'h100,     0,         0,            0,            0, 32'h0,         1, 0, 0, 0, 0);
        ta[2]  = mk(6'b100000, 0,           0,         0,            0,            0, 32'h0,         1, 0, 0, 0, 0);
        ta[3]  = mk(6'b000000, 0,           0,         0,            0,            1, 32'h4,         1, 1, 0, 0, 0);
        ta[4]  = mk(6'b000000, 0,           0,         0,            32'h4,        1, 32'h8,         1, 1, 0, 0, 0);
        ta[5]  = mk(6'b000000, 0,           0,         0,            32'h8,        1, 32'hC,         1, 1, 0, 0, 0);
        ta[6]  = mk(6'b000111, 32'h100,     32'h200,   32'h300,      32'h10,       1, 32'h100,       1, 1, 1, 0, 0);
        ta[7]  = mk(6'b000001, 0,           0,         32'h40,       32'h100,      1, 32'h44,        1, 1, 1, 1, 0);
        ta[8]  = mk(6'b000011, 0,           32'h80,    32'h40,       32'h44,       1, 32'h80,        1, 1, 1, 2, 0);
        ta[9]  = mk(6'b000000, 0,           0,         0,            32'h80,       1, 32'h84,        1, 1, 0, 3, 0);
        ta[10] = mk(6'b001000, 0,           0,         0,            32'h84,       1, DC,            0, 0, 0, 3, 0);
        ta[11] = mk(6'b001100, 32'h200,     0,         0,            32'h84,       1, 32'h200,       1, 1, 1, 3, 1);
        ta[12] = mk(6'b010100, 32'h300,     0,         0,            32'h200,      1, DC,            0, 0, 0, 4, 1);
        ta[13] = mk(6'b001100, 32'h300,     0,         0,            32'h200,      3, DC,            0, 0, 0, 4, 1);
        ta[14] = mk(6'b100000, 0,           0,         0,            32'h200,      3, DC,            0, 0, 0, 4, 1);
        ta[15] = mk(6'b000000, 0,           0,         0,            32'h200,      1, 32'h204,       1, 1, 0, 4, 1);
        ta[16] = mk(6'b100000, 0,           0,         0,            32'hFFFFFFFC, 1, 32'h0,         1, 1, 0, 4, 1);
        ta[17] = mk(6'b000001, 0,           0,         32'hFFFFFFFC, 32'h0,        1, 32'h0,         1, 1, 1, 4, 1);
        ta[18] = mk(6'b010000, 0,           0,         0,            32'h0,        1, DC,            0, 0, 0, 5, 1);

        tb[0]  = mk(6'b100000, 0,           0,         0,            0,            0, 32'h0,         1, 0, 0, 0, 0);
        tb[1]  = mk(6'b000010, 0,           32'h80,    0,            0,            1, 32'h80,        1, 1, 1, 0, 0);
        tb[2]  = mk(6'b000000, 0,           0,         0,            32'h80,       2, 32'h84,        1, 1, 1, 1, 0);
        tb[3]  = mk(6'b010000, 0,           0,         0,            32'h84,       2, 32'h88,        1, 1, 1, 1, 0);
        tb[4]  = mk(6'b000000, 0,           0,         0,            32'h88,       1, 32'h8C,        1, 1, 0, 1, 0);
        tb[5]  = mk(6'b000010, 0,           32'h80,    0,            32'h8C,       1, 32'h80,        1, 1, 1, 1, 0);
        tb[6]  = mk(6'b001000, 0,           0,         0,            32'h80,       2, DC,            0, 1, 1, 2, 0);
        tb[7]  = mk(6'b000000, 0,           0,         0,            32'h80,       2, 32'h84,        1, 1, 1, 2, 0);
        tb[8]  = mk(6'b000000, 0,           0,         0,            32'h84,       2, 32'h88,        1, 1, 1, 2, 0);
        tb[9]  = mk(6'b000000, 0,           0,         0,            32'h88,       1, 32'h8C,        1, 1, 0, 2, 0);
        tb[10] = mk(6'b000100, 32'h40,      0,         0,            32'h8C,       1, 32'h40,        1, 1, 1, 2, 0);
        tb[11] = mk(6'b000000, 0,           0,         0,            32'h40,       2, 32'h44,        1, 1, 1, 3, 0);
        tb[12] = mk(6'b000010, 0,           32'hC0,    0,            32'h44,       2, 32'hC0,        1, 1, 1, 3, 0);
        tb[13] = mk(6'b000000, 0,           0,         0,            32'hC0,       2, 32'hC4,        1, 1, 1, 4, 0);
        tb[14] = mk(6'b000000, 0,           0,         0,            32'hC4,       2, 32'hC8,        1, 1, 1, 4, 0);
        tb[15] = mk(6'b000000, 0,           0,         0,            32'hC8,       1, 32'hCC,        1, 1, 0, 4, 0);

        sel_b = 1'b0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 19; i++) apply(ta[i], $sformatf("A%0d", i));

        // Reset while halted must return to IDLE with clean counters.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply(mk(6'b000000, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 0), "A_rst_halt");

        sel_b = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) apply(tb[i], $sformatf("B%0d", i));

        for (int k = 0; k < 20; k++) begin
            apply(mk(6'b001000, 0, 0, 0, 32'hCC, 1, DC, 0, 0, 0, 4, 16'((k > 15) ? 15 : k)),
                  $sformatf("B_stall%0d", k));
        end
        apply(mk(6'b000000, 0, 0, 0, 32'hCC, 1, 32'hD0, 1, 1, 0, 4, 15), "B_stall_sat");
        apply(mk(6'b000010, 0, 32'h80, 0, 32'hD0, 1, 32'h80, 1, 1, 1, 4, 15), "B_to_flush");

        // Reset mid-FLUSH, with a redirect pending, must leave no flush residue.
        drive(mk(6'b000010, 0, 32'h200, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply(mk(6'b000000, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 0), "B_rst_flush");
        apply(mk(6'b100000, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 0), "B_restart");
        apply(mk(6'b000000, 0, 0, 0, 32'h0, 1, 32'h4, 1, 1, 0, 0, 0), "B_run_clean");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
